// File: rtl/dpram_clear_sequencer_if.sv
// Port-B side bundle of the clear sequencer: client request bus, clear control,
// and the RAM B-side pins. The sequencer uses the slave modport.
interface dpram_clear_sequencer_if #(
    parameter int ADDRLEN = 10,
    parameter int DATALEN = 2
);
    logic               clear_req;
    logic               busy;
    logic               clear_done;
    logic               req;
    logic               we;
    logic [ADDRLEN-1:0] addr;
    logic [DATALEN-1:0] wdata;
    logic               gnt;
    logic               rvalid;
    logic [DATALEN-1:0] rdata;
    logic [ADDRLEN-1:0] ram_addrb;
    logic [DATALEN-1:0] ram_wdatab;
    logic               ram_web;
    logic [DATALEN-1:0] ram_rdatab;

    modport slave (
        input  clear_req, req, we, addr, wdata, ram_rdatab,
        output busy, clear_done, gnt, rvalid, rdata, ram_addrb, ram_wdatab, ram_web
    );

    modport master (
        output clear_req, req, we, addr, wdata, ram_rdatab,
        input  busy, clear_done, gnt, rvalid, rdata, ram_addrb, ram_wdatab, ram_web
    );
endinterface

// File: rtl/dpram_clear_sequencer.sv
// Arbitrates RAM port B between a client and a one-entry-per-cycle zeroing sweep.
// DEPTH must lie in 1..2**ADDRLEN; the sweep pointer never runs past DEPTH-1.
module dpram_clear_sequencer #(
    parameter int ADDRLEN = 10,
    parameter int DATALEN = 2,
    parameter int DEPTH   = 1024
) (
    input logic                    clk,
    input logic                    reset_x,
    dpram_clear_sequencer_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDRLEN-1:0] LAST = ADDRLEN'(DEPTH - 1);

    state_t             state;
    logic [ADDRLEN-1:0] ptr;
    logic               pending;
    logic               clear_done_r;
    logic               rvalid_r;
    logic               gnt;

    // A same-cycle clear request wins over the client, and reset blocks grants.
    assign gnt = bus.req & (state == IDLE) & ~bus.clear_req & reset_x;

    assign bus.gnt        = gnt;
    assign bus.busy       = (state == CLEAR);
    assign bus.clear_done = clear_done_r;
    assign bus.rvalid     = rvalid_r;
    assign bus.rdata      = bus.ram_rdatab;

    always_comb begin
        bus.ram_addrb  = bus.addr;
        bus.ram_wdatab = bus.wdata;
        bus.ram_web    = 1'b0;
        if (state == CLEAR) begin
            bus.ram_addrb  = ptr;
            bus.ram_wdatab = '0;
            bus.ram_web    = 1'b1;
        end else if (gnt) begin
            bus.ram_web    = bus.we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state        <= IDLE;
            ptr          <= '0;
            pending      <= 1'b0;
            clear_done_r <= 1'b0;
            rvalid_r     <= 1'b0;
        end else begin
            clear_done_r <= 1'b0;
            rvalid_r     <= gnt & ~bus.we;
            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        clear_done_r <= 1'b1;
                        ptr          <= '0;
                        pending      <= 1'b0;
                        // Requests seen during the sweep collapse into one more sweep.
                        if (!(pending || bus.clear_req)) begin
                            state <= IDLE;
                        end
                    end else begin
                        ptr <= ptr + ADDRLEN'(1);
                        if (bus.clear_req) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dpram_clear_sequencer.md
Name: dpram_clear_sequencer

Overview:
- Owns port B of a true dual-port RAM and shares it between one client requester and a multi-cycle clear engine.
- The clear engine writes zero to every entry, one address per cycle. This replaces single-cycle bulk clear logic with one writer per port.
- Sits between the client (e.g. a predictor/table update unit) and the RAM's B-side pins. Port A is untouched; upstream logic uses busy to gate port-A reads.

Parameters:
ADDRLEN, 10, RAM address width
DATALEN, 2, RAM data width
DEPTH, 1024, number of entries swept by a clear; must satisfy 1 <= DEPTH <= 2^ADDRLEN

Ports:
clk  in  1  clock; all state updates on posedge
reset_x  in  1  synchronous reset, active-low
clear_req  in  1  request a full-RAM clear; sampled each cycle
busy  out  1  high while state is CLEAR
clear_done  out  1  one-cycle pulse after the last entry of a sweep is written
req  in  1  client port-B access request
we  in  1  client write enable; qualifies req
addr  in  ADDRLEN  client address
wdata  in  DATALEN  client write data
gnt  out  1  client access accepted this cycle (combinational)
rvalid  out  1  read data valid; one cycle after a granted read
rdata  out  DATALEN  read data; equals ram_rdatab
ram_addrb  out  ADDRLEN  to RAM addrb
ram_wdatab  out  DATALEN  to RAM wdatab
ram_web  out  1  to RAM web
ram_rdatab  in  DATALEN  from RAM rdatab

Behaviour:
- States: IDLE, CLEAR. Registers: state, ptr[ADDRLEN], pending, clear_done, rvalid.
- Reset (reset_x low at posedge):
  - state=IDLE, ptr=0, pending=0, clear_done=0, rvalid=0.
  - Hence busy=0 and gnt=0 while reset is low.
  - Reset mid-sweep aborts the sweep with no clear_done; RAM contents are then unspecified.
- gnt = req & (state==IDLE) & ~clear_req & reset_x. clear_req has priority over a same-cycle client req.
- RAM mux:
  - When gnt=1: ram_addrb=addr, ram_wdatab=wdata, ram_web=we.
  - When state==CLEAR: ram_addrb=ptr, ram_wdatab=0, ram_web=1.
  - Otherwise: ram_web=0, ram_addrb=addr, ram_wdatab=wdata.
- IDLE transitions:
  - clear_req=1: next state CLEAR, ptr=0.
  - Otherwise: stay in IDLE.
- CLEAR, each cycle:
  - Write ptr; if ptr != DEPTH-1, ptr <= ptr+1.
  - When ptr == DEPTH-1:
    - clear_done <= 1 for exactly the next cycle.
    - If pending or clear_req is set: stay in CLEAR, ptr <= 0, pending <= 0. The sweeps are back-to-back with no IDLE gap, and clear_done still pulses between them.
    - Otherwise: state <= IDLE.
  - clear_req seen in CLEAR while ptr != DEPTH-1: pending <= 1. Multiple requests collapse into one extra sweep.
- Sweep timing: takes exactly DEPTH cycles; busy is high for DEPTH cycles per sweep. The client sees gnt=0 throughout.
- DEPTH=1: a sweep is one cycle, with clear_done on the following cycle.
- ptr arithmetic is ADDRLEN-wide and never exceeds DEPTH-1; no wrap beyond DEPTH.
- Reads:
  - rvalid <= gnt & ~we, so it is high the cycle after a granted read.
  - rdata is a passthrough of ram_rdatab.
  - rvalid stays low after granted writes and after clear cycles.
- A granted write returns no data; the RAM reads first, so rdatab holds the old value, and rvalid is low.
- The first cycle back in IDLE after a sweep accepts client requests normally.
- busy is combinational from state; clear_done and rvalid are registered.

Test Plan:
1. Reset, then hold reset_x low with req=1 -> gnt=0, busy=0, clear_done=0, rvalid=0. Release reset -> gnt=1 in the same cycle.
2. DEPTH=16, prefill all entries with 2'b11. Pulse clear_req at cycle T:
   - Required: busy high T+1..T+16; ram_web=1 with ram_addrb=0..15 in order; clear_done only at T+17.
   - Port-A reads afterwards return 0 for all 16 entries.
3. Client write addr=5 data=2'b10 with gnt=1, then a read of addr=5 -> rvalid=1 the next cycle with rdata=2'b10. The write cycle itself gives rvalid=0.
4. Assert req=1 and clear_req=1 in the same cycle -> gnt=0, no RAM write from the client, sweep starts next cycle. req held through the sweep -> gnt=0 until busy falls, then gnt=1.
5. clear_req pulsed twice during a sweep (at ptr=3 and ptr=9):
   - Exactly one extra sweep, back-to-back, with no IDLE cycle.
   - clear_done pulses twice in total, DEPTH cycles apart.
   - busy is high continuously for 2*DEPTH cycles.
6. reset_x low at ptr=7 mid-sweep -> next cycle state IDLE, busy=0, ptr=0, no clear_done, pending cleared. A subsequent clear_req starts a fresh sweep at addr 0.
